// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Run/halt sequencer around the pipelined CPU and its data RAM.
// A start pulse launches a run. The pipeline is enabled until the halt word
// reaches decode, or until the watchdog expires. It then stays enabled for a
// fixed drain window so that in-flight instructions retire. After that the
// controller takes the RAM port and streams every word out over valid/ready.
//
// Ports
//   clk           system clock, rising edge
//   RESET         asynchronous active-high reset
//   start         run launch pulse (honoured in IDLE/DONE only)
//   instr_d       decode-stage instruction word
//   cpu_en        pipeline enable
//   cpu_mem_*     CPU data RAM request (we/addr/wdata)
//   ram_*         arbitrated RAM port (we/addr/wdata out, rdata in, 1-cycle read)
//   dump_valid/dump_ready/dump_addr/dump_data   RAM dump stream
//   busy          RUN, DRAIN or dumping
//   done          run and dump finished
//   timeout       run ended by the watchdog rather than by the halt word
//   cycle_count   enabled cycles of the current/last run (saturating)
module cpu_run_controller #(
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 5,
    parameter int          RAM_DEPTH    = 512,
    parameter int          ADDR_W       = 9,
    parameter int          DATA_W       = 32,
    parameter int          CYC_W        = 32,
    parameter int          MAX_CYCLES   = 1000000
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start,
    input  logic [31:0]       instr_d,
    output logic              cpu_en,
    input  logic              cpu_mem_we,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_wdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_DRAIN    = 3'd2,
        S_DUMP_RD  = 3'd3,
        S_DUMP_CAP = 3'd4,
        S_DUMP_OUT = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // One spare bit keeps the width at two or more even for a one-cycle drain.
    localparam int                 DRAIN_W    = $clog2(DRAIN_CYCLES + 1) + 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  PTR_LAST   = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [CYC_W-1:0]   CYC_LIMIT  = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0]   CYC_ONES   = {CYC_W{1'b1}};

    state_t               state_r;
    state_t               state_next_s;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic [ADDR_W-1:0]    ptr_r;
    logic                 halt_s;
    logic                 start_ok_s;
    logic                 wd_hit_s;
    logic [CYC_W-1:0]     cyc_inc_s;

    // Four-state compare: an X or Z on the decode bus never counts as a halt.
    assign halt_s     = (instr_d === HALT_INSTR);
    assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));

    // Computed one bit wider so that the +1 cannot wrap before the compare.
    assign wd_hit_s = (({1'b0, cycle_count} + {{CYC_W{1'b0}}, 1'b1}) >= {1'b0, CYC_LIMIT});

    assign cyc_inc_s = (cycle_count == CYC_ONES) ? cycle_count
                                                 : cycle_count + {{(CYC_W-1){1'b0}}, 1'b1};

    // FSM state register.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_RUN: begin
                // A halt takes priority over a watchdog hit in the same cycle.
                if (halt_s || wd_hit_s) begin
                    state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
                    state_next_s = S_DUMP_RD;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_DUMP_RD:  state_next_s = S_DUMP_CAP;
            S_DUMP_CAP: state_next_s = S_DUMP_OUT;
            S_DUMP_OUT: begin
                if (!dump_ready) begin
                    state_next_s = S_DUMP_OUT;
                end else if (ptr_r == PTR_LAST) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_DUMP_RD;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath registers: drain counter, dump pointer, cycle counter, timeout flag, dump data.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            drain_cnt_r <= {DRAIN_W{1'b0}};
            ptr_r       <= {ADDR_W{1'b0}};
            cycle_count <= {CYC_W{1'b0}};
            timeout     <= 1'b0;
            dump_data   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_ok_s) begin
                        cycle_count <= {CYC_W{1'b0}};
                        timeout     <= 1'b0;
                        ptr_r       <= {ADDR_W{1'b0}};
                    end
                end
                S_RUN: begin
                    cycle_count <= cyc_inc_s;
                    if (halt_s) begin
                        drain_cnt_r <= DRAIN_LOAD;
                    end else if (wd_hit_s) begin
                        drain_cnt_r <= DRAIN_LOAD;
                        timeout     <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    cycle_count <= cyc_inc_s;
                    if (drain_cnt_r != {DRAIN_W{1'b0}}) begin
                        drain_cnt_r <= drain_cnt_r - {{(DRAIN_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DUMP_CAP: begin
                    // The read was issued in DUMP_RD, so the RAM data is valid now.
                    dump_data <= ram_rdata;
                end
                S_DUMP_OUT: begin
                    if (dump_ready && (ptr_r != PTR_LAST)) begin
                        ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    drain_cnt_r <= drain_cnt_r;
                end
            endcase
        end
    end

    // FSM output decode and RAM port arbitration.
    always_comb begin
        cpu_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dump_valid = 1'b0;
        dump_addr  = {ADDR_W{1'b0}};
        ram_we     = 1'b0;
        ram_addr   = ptr_r;
        ram_wdata  = {DATA_W{1'b0}};
        case (state_r)
            S_RUN, S_DRAIN: begin
                // The CPU owns the RAM port without any added latency.
                cpu_en    = 1'b1;
                busy      = 1'b1;
                ram_we    = cpu_mem_we;
                ram_addr  = cpu_mem_addr;
                ram_wdata = cpu_mem_wdata;
            end
            S_DUMP_RD, S_DUMP_CAP: begin
                busy = 1'b1;
            end
            S_DUMP_OUT: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
                dump_addr  = ptr_r;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                cpu_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        RESET;
    logic        start;
    logic [31:0] instr_d;
    logic        cpu_en;
    logic        cpu_mem_we;
    logic [8:0]  cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [8:0]  dump_addr;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    logic        fill;
    logic [31:0] mem [0:511];

    always #5 clk = ~clk;

    cpu_run_controller #(.MAX_CYCLES(100)) dut (
        .clk(clk), .RESET(RESET), .start(start), .instr_d(instr_d), .cpu_en(cpu_en),
        .cpu_mem_we(cpu_mem_we), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    // Synchronous RAM model, 1-cycle read latency; fill loads mem[i] = i*3.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i * 3);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b0; instr_d = 32'd0; cpu_mem_we = 1'b0;
        cpu_mem_addr = 9'd0; cpu_mem_wdata = 32'd0; dump_ready = 1'b0; fill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b0;
        checks++;
        if ({cpu_en, ram_we, dump_valid, busy, done, timeout} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000 (cpu_en,ram_we,dump_valid,busy,done,timeout)",
                     {cpu_en, ram_we, dump_valid, busy, done, timeout});
        end
        checks++;
        if (cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_cycle_count got=%0d want=0", cycle_count);
        end
        fill = 1'b1;
        tick();
        fill = 1'b0;
    endtask

    task automatic test_halt_run();
        int en_cnt;
        int first_rd;
        en_cnt   = 0;
        first_rd = -1;
        dump_ready = 1'b0;
        do_start();
        for (int k = 0; k < 40; k++) begin
            if (k == 20)     instr_d = HALT;
            else if (k == 5) instr_d = 32'bx;
            else             instr_d = 32'(k);
            cpu_mem_we = 1'b0; cpu_mem_addr = 9'd0; cpu_mem_wdata = 32'd0;
            if (k == 3) begin
                cpu_mem_we = 1'b1; cpu_mem_addr = 9'd5; cpu_mem_wdata = 32'hDEAD_BEEF;
                #1;
                checks++;
                if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 9'd5, 32'hDEAD_BEEF}) begin
                    failures++;
                    $display("FAIL run_passthrough got we=%b addr=%0d wdata=%h want we=1 addr=5 wdata=deadbeef",
                             ram_we, ram_addr, ram_wdata);
                end
            end
            if (k == 27) begin
                cpu_mem_we = 1'b1; cpu_mem_addr = 9'd5; cpu_mem_wdata = 32'h1234_5678;
                #1;
                checks++;
                if ({ram_we, ram_wdata} !== {1'b0, 32'd0}) begin
                    failures++;
                    $display("FAIL dump_blocks_cpu got we=%b wdata=%h want we=0 wdata=0", ram_we, ram_wdata);
                end
            end
            if (cpu_en) en_cnt++;
            if (first_rd < 0 && !cpu_en) first_rd = k;
            tick();
        end
        cpu_mem_we = 1'b0; instr_d = 32'd0;
        checks++;
        if (en_cnt != 26) begin
            failures++;
            $display("FAIL cpu_en_cycles got=%0d want=26", en_cnt);
        end
        checks++;
        if (first_rd != 26) begin
            failures++;
            $display("FAIL first_dump_cycle got=%0d want=26 (0-based)", first_rd);
        end
        checks++;
        if (cycle_count !== 32'd26) begin
            failures++;
            $display("FAIL halt_cycle_count got=%0d want=26", cycle_count);
        end
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL halt_timeout got=%b want=0", timeout);
        end
        checks++;
        if (mem[5] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_word5 got=%h want=deadbeef", mem[5]);
        end
        checks++;
        if ({dump_valid, dump_addr} !== {1'b1, 9'd0}) begin
            failures++;
            $display("FAIL stalled_beat0 got valid=%b addr=%0d want valid=1 addr=0", dump_valid, dump_addr);
        end
    endtask

    task automatic test_full_dump();
        int n;
        int beat;
        int done_at;
        logic prev_busy;
        #2 RESET = 1'b1;
        #1 RESET = 1'b0;
        fill = 1'b1;
        tick();
        fill = 1'b0;
        do_start();
        instr_d = HALT;
        tick();
        instr_d = 32'd0;
        n = 0;
        while (cpu_en && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_length got=%0d busy=%b want=5 busy=1", n, busy);
        end
        dump_ready = 1'b1;
        beat = 0; done_at = -1; prev_busy = busy;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin
                done_at = c;
                break;
            end
            if (dump_valid) begin
                checks++;
                if (dump_addr !== 9'(beat) || dump_data !== 32'(beat * 3)) begin
                    failures++;
                    $display("FAIL dump_beat got addr=%0d data=%0d want addr=%0d data=%0d",
                             dump_addr, dump_data, beat, beat * 3);
                end
                beat++;
            end
            prev_busy = busy;
            tick();
        end
        checks++;
        if (done_at != 1536) begin
            failures++;
            $display("FAIL done_latency got=%0d want=1536", done_at);
        end
        checks++;
        if (beat != 512) begin
            failures++;
            $display("FAIL beat_count got=%0d want=512", beat);
        end
        checks++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_fall got busy=%b prev=%b want busy=0 prev=1", busy, prev_busy);
        end
        checks++;
        if (cycle_count !== 32'd6) begin
            failures++;
            $display("FAIL frozen_cycle_count got=%0d want=6", cycle_count);
        end
    endtask

    task automatic test_timeout_stall();
        int en_cnt;
        int n;
        dump_ready = 1'b1;
        instr_d = 32'd0;
        do_start();
        en_cnt = 0;
        while (cpu_en && en_cnt < 300) begin
            en_cnt++;
            tick();
        end
        checks++;
        if (en_cnt != 105 || cycle_count !== 32'd105) begin
            failures++;
            $display("FAIL watchdog_cycles got en=%0d count=%0d want 105", en_cnt, cycle_count);
        end
        checks++;
        if (timeout !== 1'b1) begin
            failures++;
            $display("FAIL watchdog_timeout got=%b want=1", timeout);
        end
        n = 0;
        while (!(dump_valid && dump_addr == 9'd7) && n < 100) begin
            tick();
            n++;
        end
        dump_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({dump_valid, dump_addr, dump_data} !== {1'b1, 9'd7, 32'd21}) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got valid=%b addr=%0d data=%0d want 1/7/21",
                         j, dump_valid, dump_addr, dump_data);
            end
            tick();
        end
        dump_ready = 1'b1;
        tick();
        n = 0;
        while (!dump_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if ({dump_valid, dump_addr, dump_data} !== {1'b1, 9'd8, 32'd24}) begin
            failures++;
            $display("FAIL after_stall got valid=%b addr=%0d data=%0d want 1/8/24",
                     dump_valid, dump_addr, dump_data);
        end
        n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_run_done got done=%b timeout=%b want 1/1", done, timeout);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        dump_ready = 1'b1;
        do_start();
        instr_d = HALT;
        tick();
        instr_d = 32'd0;
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL start_clears_timeout got=%b want=0", timeout);
        end
        n = 0;
        while (!(dump_valid && dump_addr == 9'd300) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL reach_addr300 got=timeout want=beat 300");
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({cpu_en, ram_we, dump_valid, busy, done, timeout} !== 6'b0 || cycle_count !== 32'd0
            || dump_addr !== 9'd0 || dump_data !== 32'd0 || ram_addr !== 9'd0) begin
            failures++;
            $display("FAIL async_abort got flags=%b count=%0d daddr=%0d ddata=%0d raddr=%0d want all 0",
                     {cpu_en, ram_we, dump_valid, busy, done, timeout}, cycle_count,
                     dump_addr, dump_data, ram_addr);
        end
        @(posedge clk);
        #1 RESET = 1'b0;
        do_start();
        instr_d = HALT;
        tick();
        instr_d = 32'd0;
        n = 0;
        while (!dump_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if ({dump_valid, dump_addr, dump_data} !== {1'b1, 9'd0, 32'd0}) begin
            failures++;
            $display("FAIL restart_beat0 got valid=%b addr=%0d data=%0d want 1/0/0",
                     dump_valid, dump_addr, dump_data);
        end
        tick();
        n = 0;
        while (!dump_valid && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if ({dump_valid, dump_addr, dump_data} !== {1'b1, 9'd1, 32'd3}) begin
            failures++;
            $display("FAIL restart_beat1 got valid=%b addr=%0d data=%0d want 1/1/3",
                     dump_valid, dump_addr, dump_data);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=hung want=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_halt_run();
        test_full_dump();
        test_timeout_stall();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/halt sequencer wrapped around the pipelined CPU and its 512-word data RAM.
- Starts the pipeline, watches the decode-stage instruction for the halt word, and keeps the pipeline enabled for a fixed drain window so in-flight instructions retire.
- Then takes over the data RAM port and streams every word out over a valid/ready interface.
- Owns the RAM port arbitration between the CPU and the dump engine, and counts executed cycles.

Parameters:
HALT_INSTR, 32'hFFFF_FFFF, decode-stage instruction word that ends a program
DRAIN_CYCLES, 5, cycles the pipeline stays enabled after halt is detected (>=1)
RAM_DEPTH, 512, number of data RAM words dumped
ADDR_W, 9, RAM address width (clog2 RAM_DEPTH)
DATA_W, 32, RAM data width
CYC_W, 32, cycle counter width
MAX_CYCLES, 1000000, watchdog limit on run cycles

Ports:
clk  in  1  single system clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that launches a run; honoured only in IDLE or DONE
instr_d  in  32  CPU decode-stage instruction
cpu_en  out  1  pipeline enable; CPU advances only while high
cpu_mem_we  in  1  CPU data RAM write enable
cpu_mem_addr  in  ADDR_W  CPU data RAM address
cpu_mem_wdata  in  DATA_W  CPU data RAM write data
ram_we  out  1  arbitrated RAM write enable
ram_addr  out  ADDR_W  arbitrated RAM address
ram_wdata  out  DATA_W  arbitrated RAM write data
ram_rdata  in  DATA_W  RAM read data, synchronous, 1-cycle latency
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump sink ready
dump_addr  out  ADDR_W  address of current dump beat
dump_data  out  DATA_W  data of current dump beat (registered)
busy  out  1  high in RUN, DRAIN and any DUMP state
done  out  1  high in DONE
timeout  out  1  run ended by the watchdog, not by HALT_INSTR
cycle_count  out  CYC_W  cycles with cpu_en=1 in the current or last run

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; drain counter=0; dump pointer=0; cycle_count=0.
- States: IDLE, RUN, DRAIN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE.
- IDLE/DONE: cpu_en=0, ram_we=0. start -> RUN, clearing cycle_count, timeout, done and the dump pointer.
- RUN:
  - cpu_en=1; cycle_count increments every cycle.
  - If instr_d==HALT_INSTR at a rising edge (4-state equality; X never matches), go to DRAIN with drain counter=DRAIN_CYCLES-1. The detection cycle counts as a run cycle.
  - If cycle_count+1 reaches MAX_CYCLES without a halt: timeout<=1, go to DRAIN. Halt wins if both occur in the same cycle; timeout stays 0.
- DRAIN:
  - cpu_en=1; cycle_count increments.
  - Counter decrements each cycle; at 0 go to DUMP_RD. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
  - Further halt words are ignored.
- RAM arbitration:
  - In RUN/DRAIN, ram_we/ram_addr/ram_wdata = cpu_mem_* (combinational pass-through, zero added latency).
  - In all other states, ram_we=0 and ram_wdata=0; CPU requests are dropped.
- Dump engine:
  - DUMP_RD: ram_addr=pointer.
  - DUMP_CAP: ram_addr held; dump_data<=ram_rdata.
  - DUMP_OUT: dump_valid=1, dump_addr=pointer, ram_addr held.
  - dump_valid, dump_addr and dump_data stay stable until dump_ready=1 at a rising edge.
  - On that handshake: if pointer==RAM_DEPTH-1, go to DONE; else pointer+1, go to DUMP_RD.
  - Minimum 3 cycles per word; no address skipped or repeated.
- dump_valid is 0 outside DUMP_OUT.
- done stays high until start or RESET.
- cycle_count freezes from the end of DRAIN until the next start and saturates at all-ones.
- start outside IDLE/DONE is ignored.
- Reset mid-run or mid-dump aborts immediately. Next start dumps from address 0.

Test Plan:
- Assert RESET for 2 cycles, release -> cpu_en, ram_we, dump_valid, busy, done, timeout = 0; cycle_count=0.
- start, 20 non-halt instr_d, then HALT_INSTR -> cpu_en high exactly 26 cycles (21 RUN + 5 DRAIN); cycle_count=26; timeout=0; first DUMP_RD on cycle 27.
- In RUN, drive cpu_mem_we=1, addr=5, wdata=32'hDEAD_BEEF -> same-cycle ram_we=1, ram_addr=5, ram_wdata=32'hDEAD_BEEF. Repeat in DUMP_CAP -> ram_we=0, RAM word 5 unchanged.
- Preload RAM[i]=i*3, dump_ready=1 constantly -> 512 beats at addr 0..511 with data i*3; done rises 1536 cycles after dump start; busy falls the same cycle.
- Hold dump_ready=0 for 4 cycles at beat addr 7 -> dump_valid=1, dump_addr=7, dump_data=21 stable all 4 cycles; next beat is addr 8.
- With MAX_CYCLES=100 and no halt -> timeout=1, cycle_count=105, dump and DONE complete. Assert RESET mid-dump at addr 300 -> all outputs 0 asynchronously; next start dumps from addr 0.
